// File: rtl/fifo_umbral_if.sv
// Lane FIFO bus: push/pop handshake, live thresholds and status flags.
// master drives requests and thresholds, slave (the FIFO) drives data and flags.
interface fifo_umbral_if #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int THR_W  = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [THR_W-1:0]  umbral_empty;
  logic [THR_W-1:0]  umbral_full;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic              error;

  modport master (
    output wr_en, data_in, rd_en, umbral_empty, umbral_full,
    input  data_out, valid_out, empty, full, almost_empty, almost_full, count, error
  );

  modport slave (
    input  wr_en, data_in, rd_en, umbral_empty, umbral_full,
    output data_out, valid_out, empty, full, almost_empty, almost_full, count, error
  );
endinterface

// File: rtl/fifo_umbral.sv
// Per-lane synchronous FIFO with programmable almost-empty/almost-full flags.
// Optional macro FIFO_BYPASS_EN: a push+pop on an empty FIFO forwards data_in straight to data_out.
module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int THR_W  = 5
) (
  input logic           clk,
  input logic           rst,
  fifo_umbral_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CMP_W = (CW > THR_W) ? CW : THR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              error_q;

  logic              empty_w;
  logic              full_w;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              overflow;
  logic              underflow;
  logic [CMP_W-1:0]  count_ext;
  logic [CMP_W-1:0]  thr_empty_ext;
  logic [CMP_W-1:0]  thr_full_ext;

  assign empty_w = (count_q == CW'(0));
  assign full_w  = (count_q == CW'(DEPTH));

`ifdef FIFO_BYPASS_EN
  assign bypass = !rst && empty_w && bus.wr_en && bus.rd_en;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (!rst && !bypass) begin
      push      = bus.wr_en && (!full_w || bus.rd_en);
      pop       = bus.rd_en && !empty_w;
      overflow  = bus.wr_en && full_w && !bus.rd_en;
      underflow = bus.rd_en && empty_w && !bus.wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr];
      end else if (bypass) begin
        data_q <= bus.data_in;
      end
      valid_q <= pop || bypass;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (overflow || underflow) begin
        error_q <= 1'b1;
      end
    end
  end

  // Zero-extended compare makes out-of-range thresholds saturate naturally.
  assign count_ext     = CMP_W'(count_q);
  assign thr_empty_ext = CMP_W'(bus.umbral_empty);
  assign thr_full_ext  = CMP_W'(bus.umbral_full);

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_ext <= thr_empty_ext);
  assign bus.almost_full  = (count_ext >= thr_full_ext);
  assign bus.count        = count_q;
  assign bus.error        = error_q;
endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: vector table for fill/drain/overflow plus hand sequences.
module tb_fifo_umbral;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int THR_W  = 5;

  typedef struct {
    string      tag;
    logic       r;
    logic       w;
    logic       rd;
    logic [5:0] din;
    logic [4:0] ue;
    logic [4:0] uf;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ae;
    logic       af;
    logic       vld;
    logic [5:0] dout;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [4:0] cur_ue = 5'd2;
  logic [4:0] cur_uf = 5'd6;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THR_W(THR_W)) bus ();

  fifo_umbral #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THR_W(THR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [5:0] din,
                               input logic [4:0] ue, input logic [4:0] uf);
    @(negedge clk);
    rst              = r;
    bus.wr_en        = w;
    bus.rd_en        = rd;
    bus.data_in      = din;
    bus.umbral_empty = ue;
    bus.umbral_full  = uf;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [5:0] din);
    applyStimulus(r, w, rd, din, cur_ue, cur_uf);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] cnt, input logic emp, input logic ful,
                             input logic ae, input logic af, input logic vld, input logic [5:0] dout,
                             input logic err);
    cmp({tag, ".count"}, 16'(bus.count), 16'(cnt));
    cmp({tag, ".empty"}, 16'(bus.empty), 16'(emp));
    cmp({tag, ".full"}, 16'(bus.full), 16'(ful));
    cmp({tag, ".almost_empty"}, 16'(bus.almost_empty), 16'(ae));
    cmp({tag, ".almost_full"}, 16'(bus.almost_full), 16'(af));
    cmp({tag, ".valid_out"}, 16'(bus.valid_out), 16'(vld));
    cmp({tag, ".data_out"}, 16'(bus.data_out), 16'(dout));
    cmp({tag, ".error"}, 16'(bus.error), 16'(err));
  endtask

  function automatic vec_t mk(string tag, logic r, logic w, logic rd, logic [5:0] din,
                              logic [3:0] cnt, logic emp, logic ful, logic ae, logic af,
                              logic vld, logic [5:0] dout, logic err);
    vec_t v;
    v.tag = tag; v.r = r; v.w = w; v.rd = rd; v.din = din; v.ue = 5'd2; v.uf = 5'd6;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.ae = ae; v.af = af;
    v.vld = vld; v.dout = dout; v.err = err;
    return v;
  endfunction

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
    bus.umbral_empty = 5'd2; bus.umbral_full = 5'd6;

    // Thresholds 2/6: almost_empty for count<=2, almost_full for count>=6.
    vecs.push_back(mk("reset0", 1, 0, 0, 6'h00, 0, 1, 0, 1, 0, 0, 6'h00, 0));
    vecs.push_back(mk("reset1", 1, 0, 0, 6'h00, 0, 1, 0, 1, 0, 0, 6'h00, 0));
    for (int pass = 0; pass < 2; pass++) begin
      logic [5:0] hold;
      logic       err;
      hold = (pass == 0) ? 6'h00 : 6'h08;
      err  = 1'b0;
      for (int k = 1; k <= 8; k++)
        vecs.push_back(mk($sformatf("p%0d_push%0d", pass, k), 0, 1, 0, 6'(k), 4'(k), 0, k == 8,
                          k <= 2, k >= 6, 0, hold, 0));
      if (pass == 1) begin
        vecs.push_back(mk("overflow", 0, 1, 0, 6'h3F, 8, 0, 1, 0, 1, 0, hold, 1));
        err = 1'b1;
      end
      for (int j = 1; j <= 8; j++)
        vecs.push_back(mk($sformatf("p%0d_pop%0d", pass, j), 0, 0, 1, 6'h00, 4'(8 - j), j == 8, 0,
                          j >= 6, j <= 2, 1, 6'(j), err));
      vecs.push_back(mk($sformatf("p%0d_idle", pass), 0, 0, 0, 6'h00, 0, 1, 0, 1, 0, 0, 6'h08, err));
    end
    vecs.push_back(mk("reset_clr", 1, 0, 0, 6'h00, 0, 1, 0, 1, 0, 0, 6'h00, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].din, vecs[i].ue, vecs[i].uf);
      checkOutput(vecs[i].tag, vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].ae, vecs[i].af,
                  vecs[i].vld, vecs[i].dout, vecs[i].err);
    end

    // Steady state at count 4 with simultaneous push/pop; pointers wrap twice.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 6'(8'h10 + k));
      checkOutput($sformatf("w_fill%0d", k), 4'(k + 1), 0, 0, k < 2, 0, 0, 6'h00, 0);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 6'(8'h14 + i));
      checkOutput($sformatf("wrap%0d", i), 4, 0, 0, 0, 0, 1, 6'(8'h10 + i), 0);
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 1, 6'h00);
      checkOutput($sformatf("w_drain%0d", j), 4'(3 - j), j == 3, 0, j >= 1, 0, 1, 6'(8'h24 + j), 0);
    end

    // Push and pop together on an empty FIFO.
    step(0, 1, 1, 6'h2A);
`ifdef FIFO_BYPASS_EN
    checkOutput("bypass", 0, 1, 0, 1, 0, 1, 6'h2A, 0);
    step(0, 0, 0, 6'h00);
    checkOutput("bypass_idle", 0, 1, 0, 1, 0, 0, 6'h2A, 0);
`else
    checkOutput("empty_rw", 1, 0, 0, 1, 0, 0, 6'h27, 0);
    step(0, 0, 1, 6'h00);
    checkOutput("empty_rw_pop", 0, 1, 0, 1, 0, 1, 6'h2A, 0);
`endif

    // Underflow sets the sticky error; only a mid-run reset clears it and the stored words.
    step(0, 0, 1, 6'h00);
    checkOutput("underflow", 0, 1, 0, 1, 0, 0, 6'h2A, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 6'(8'h31 + k));
      checkOutput($sformatf("r_fill%0d", k), 4'(k + 1), 0, 0, k < 2, 0, 0, 6'h2A, 1);
    end
    step(1, 1, 0, 6'h3E);
    checkOutput("mid_reset", 0, 1, 0, 1, 0, 0, 6'h00, 0);
    step(0, 1, 0, 6'h05);
    step(0, 1, 0, 6'h06);
    checkOutput("post_rst_fill", 2, 0, 0, 1, 0, 0, 6'h00, 0);
    step(0, 0, 1, 6'h00);
    checkOutput("post_rst_pop0", 1, 0, 0, 1, 0, 1, 6'h05, 0);
    step(0, 0, 1, 6'h00);
    checkOutput("post_rst_pop1", 0, 1, 0, 1, 0, 1, 6'h06, 0);

    // Threshold boundaries: above DEPTH, exactly DEPTH, and zero.
    cur_uf = 5'd9;
    step(1, 0, 0, 6'h00);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 6'(k));
    checkOutput("uf9_full", 8, 0, 1, 0, 0, 0, 6'h00, 0);
    cur_uf = 5'd8;
    step(0, 0, 0, 6'h00);
    checkOutput("uf8_full", 8, 0, 1, 0, 1, 0, 6'h00, 0);
    cur_ue = 5'd8;
    step(0, 0, 0, 6'h00);
    checkOutput("ue8_full", 8, 0, 1, 1, 1, 0, 6'h00, 0);
    cur_ue = 5'd31;
    step(0, 0, 0, 6'h00);
    checkOutput("ue31_full", 8, 0, 1, 1, 1, 0, 6'h00, 0);
    cur_ue = 5'd2;
    cur_uf = 5'd0;
    step(1, 0, 0, 6'h00);
    checkOutput("uf0_empty", 0, 1, 0, 1, 1, 0, 6'h00, 0);
    cur_uf = 5'd1;
    step(0, 0, 0, 6'h00);
    checkOutput("uf1_empty", 0, 1, 0, 1, 0, 0, 6'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
